// File: rtl/io_mux_switcher_if.sv
// Bundles the request handshake, the io_mux side and the pad side of io_mux_switcher.
// Exposes the controller state for checkers.
interface io_mux_switcher_if #(
  parameter int FWIDTH  = 1,
  parameter int RXCOUNT = 1
);
  // Handshake: a request transfers on a rising clk edge where req_valid && req_ready.
  // The requester holds req_select stable while req_valid is high and ready is low.
  // done (with err) pulses for one cycle when the transferred request has been applied.
  logic               req_valid;
  logic [FWIDTH-1:0]  req_select;
  logic               req_ready;
  logic               done;
  logic               err;

  logic [FWIDTH-1:0]  mux_select;
  logic               mux_pin_ena;
  logic [RXCOUNT-1:0] mux_func_receive;

  logic               pin_ena;
  logic [RXCOUNT-1:0] func_receive;
  logic               busy;
  logic [1:0]         dbg_state;

  modport master (
    output req_valid, req_select, mux_pin_ena, mux_func_receive,
    input  req_ready, done, err, mux_select, pin_ena, func_receive, busy, dbg_state
  );

  modport slave (
    input  req_valid, req_select, mux_pin_ena, mux_func_receive,
    output req_ready, done, err, mux_select, pin_ena, func_receive, busy, dbg_state
  );
endinterface

// File: rtl/io_mux_switcher.sv
// Break-before-make controller for io_mux func_select: gates pad enable and receive
// vector for a guard window before and a settle window after each select change.
module io_mux_switcher #(
  parameter int RXCOUNT       = 1,
  parameter int TXCOUNT       = 1,
  parameter int GUARD_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2,
  parameter int RESET_SELECT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  io_mux_switcher_if.slave  bus
);
  localparam int FCOUNT = RXCOUNT + TXCOUNT;
  localparam int FWIDTH = (FCOUNT > 1) ? $clog2(FCOUNT) : 1;
  localparam int CMAX   = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
  localparam int CWIDTH = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [CWIDTH-1:0] GUARD_LOAD  = CWIDTH'(GUARD_CYCLES - 1);
  localparam logic [CWIDTH-1:0] SETTLE_LOAD = CWIDTH'(SETTLE_CYCLES - 1);
  localparam logic [FWIDTH-1:0] RESET_SEL   = FWIDTH'(RESET_SELECT);
  localparam logic [FWIDTH:0]   FCOUNT_W    = (FWIDTH + 1)'(FCOUNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CWIDTH-1:0]   cnt_q, cnt_d;
  logic [FWIDTH-1:0]   pending_q, pending_d;
  logic [FWIDTH-1:0]   sel_q, sel_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                gate;
  logic                accept;
  logic                sel_out_of_range;

  assign gate             = (state_q != IDLE);
  assign accept           = (state_q == IDLE) && bus.req_valid;
  assign sel_out_of_range = ({1'b0, bus.req_select} >= FCOUNT_W);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    sel_d     = sel_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pending_d = bus.req_select;
          // Invalid and no-op requests complete without ever touching the gate.
          if (sel_out_of_range) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (bus.req_select == sel_q) begin
            done_d = 1'b1;
          end else begin
            state_d = DRAIN;
            cnt_d   = GUARD_LOAD;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          sel_d   = pending_q;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
      sel_q     <= RESET_SEL;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Gating follows the registered state, so the accept cycle still passes the old function.
  assign bus.req_ready    = ~gate;
  assign bus.busy         = gate;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.mux_select   = sel_q;
  assign bus.pin_ena      = bus.mux_pin_ena & ~gate;
  assign bus.func_receive = gate ? '0 : bus.mux_func_receive;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_io_mux_switcher.sv
// Bench for io_mux_switcher: per-feature tasks with inline checks plus a done/err
// scoreboard fed on every accepted request.
module tb_io_mux_switcher;
  localparam int RX = 3;
  localparam int TX = 2;
  localparam int GUARD = 2;
  localparam int SETTLE = 3;
  localparam int FW = 3;
  localparam int FC = RX + TX;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  // Each entry is {err, mux_select expected when done pulses}.
  logic [FW:0] exp_q[$];
  logic [FW-1:0] model_sel = '0;
  logic [FW:0] mon_exp;
  logic [FW:0] mon_got;

  always #5 clk = ~clk;

  io_mux_switcher_if #(.FWIDTH(FW), .RXCOUNT(RX)) bus ();

  io_mux_switcher #(
    .RXCOUNT(RX), .TXCOUNT(TX), .GUARD_CYCLES(GUARD),
    .SETTLE_CYCLES(SETTLE), .RESET_SELECT(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always @(negedge clk) begin
    if (rst_n && bus.err && !bus.done) begin
      vectors++;
      miscompares++;
      $display("FAIL err_without_done got err=1 done=0 required err=0");
    end
    if (rst_n && bus.done) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL done_unexpected got done=1 err=%0b sel=%0d required no done", bus.err, bus.mux_select);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_got = {bus.err, bus.mux_select};
        if (mon_got !== mon_exp) begin
          miscompares++;
          $display("FAIL done_result got err=%0b sel=%0d required err=%0b sel=%0d",
                   mon_got[FW], mon_got[FW-1:0], mon_exp[FW], mon_exp[FW-1:0]);
        end
      end
    end
  end

  task automatic push_expected(input logic [FW-1:0] sel);
    if (int'(sel) >= FC) begin
      exp_q.push_back({1'b1, model_sel});
    end else begin
      exp_q.push_back({1'b0, sel});
      model_sel = sel;
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge (cycle E+1).
  task automatic do_accept(input logic [FW-1:0] sel);
    int n = 0;
    bus.req_valid  = 1'b1;
    bus.req_select = sel;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (!bus.req_ready) begin
      miscompares++;
      $display("FAIL accept_timeout got req_ready=0 required 1 within 50 cycles");
      bus.req_valid = 1'b0;
      return;
    end
    push_expected(sel);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_select = '0;
    bus.mux_pin_ena = 1'b1;
    bus.mux_func_receive = 3'b001;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (bus.mux_select !== 3'd0) begin miscompares++; $display("FAIL rst_mux_select got %0d required 0", bus.mux_select); end
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready got %0b required 1", bus.req_ready); end
    vectors++; if (bus.func_receive !== 3'b001) begin miscompares++; $display("FAIL rst_func_receive got %b required 001", bus.func_receive); end
    vectors++; if (bus.pin_ena !== 1'b1) begin miscompares++; $display("FAIL rst_pin_ena got %0b required 1", bus.pin_ena); end
    vectors++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin miscompares++; $display("FAIL rst_done_err got %0b%0b required 00", bus.done, bus.err); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got %0b required 0", bus.busy); end
  endtask

  task automatic test_switch();
    logic [RX-1:0] rx;
    do_accept(3'd4);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      rx = RX'($urandom_range(1, 7));
      bus.mux_func_receive = rx;
      #1;
      if (k <= 5) begin
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL sw_busy k=%0d got %0b required 1", k, bus.busy); end
        vectors++; if (bus.pin_ena !== 1'b0) begin miscompares++; $display("FAIL sw_pin_ena k=%0d got %0b required 0", k, bus.pin_ena); end
        vectors++; if (bus.func_receive !== 3'b000) begin miscompares++; $display("FAIL sw_func_receive k=%0d got %b required 000", k, bus.func_receive); end
        vectors++; if (bus.mux_select !== ((k <= 2) ? 3'd0 : 3'd4)) begin miscompares++; $display("FAIL sw_mux_select k=%0d got %0d required %0d", k, bus.mux_select, (k <= 2) ? 0 : 4); end
      end else begin
        vectors++; if (bus.done !== 1'b1 || bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL sw_done_ready k=6 got done=%0b ready=%0b required 1 1", bus.done, bus.req_ready); end
        vectors++; if (bus.pin_ena !== 1'b1 || bus.func_receive !== rx) begin miscompares++; $display("FAIL sw_ungated got pin=%0b rx=%b required 1 %b", bus.pin_ena, bus.func_receive, rx); end
      end
    end
    bus.mux_func_receive = 3'b001;
  endtask

  task automatic test_noop();
    do_accept(3'd4);
    vectors++; if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL noop_gate got busy=%0b ready=%0b required 0 1", bus.busy, bus.req_ready); end
    vectors++; if (bus.done !== 1'b1 || bus.err !== 1'b0) begin miscompares++; $display("FAIL noop_done got done=%0b err=%0b required 1 0", bus.done, bus.err); end
    vectors++; if (bus.mux_select !== 3'd4) begin miscompares++; $display("FAIL noop_sel got %0d required 4", bus.mux_select); end
  endtask

  task automatic test_error();
    do_accept(3'd6);
    vectors++; if (bus.done !== 1'b1 || bus.err !== 1'b1) begin miscompares++; $display("FAIL err_pulse got done=%0b err=%0b required 1 1", bus.done, bus.err); end
    for (int k = 1; k <= 3; k++) begin
      vectors++; if (bus.busy !== 1'b0 || bus.mux_select !== 3'd4) begin miscompares++; $display("FAIL err_idle k=%0d got busy=%0b sel=%0d required 0 4", k, bus.busy, bus.mux_select); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    do_accept(3'd1);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL rm_drain got busy=%0b required 1", bus.busy); end
    rst_n = 1'b0;
    exp_q.delete();
    model_sel = '0;
    #1;
    vectors++; if (bus.mux_select !== 3'd0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL rm_async got sel=%0d busy=%0b required 0 0", bus.mux_select, bus.busy); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++; if (bus.req_ready !== 1'b1 || bus.mux_select !== 3'd0 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL rm_release got ready=%0b sel=%0d busy=%0b required 1 0 0", bus.req_ready, bus.mux_select, bus.busy); end
    for (int k = 0; k < 8; k++) begin
      if (bus.done === 1'b1) ndone++;
      @(posedge clk); #1;
    end
    vectors++; if (ndone !== 0) begin miscompares++; $display("FAIL rm_no_done got %0d pulses required 0", ndone); end
  endtask

  task automatic test_back_to_back();
    int d1 = -1;
    int d2 = -1;
    int ndone = 0;
    bus.req_valid = 1'b1;
    bus.req_select = 3'd4;
    push_expected(3'd4);
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        ndone++;
        if (d1 < 0) d1 = k; else d2 = k;
      end
      if (k == 1) begin
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_first_accept got busy=%0b required 1", bus.busy); end
        bus.req_select = 3'd1;
      end
      if (k == 2 || k == 3 || k == 8 || k == 9) begin
        vectors++;
        if (bus.mux_select !== ((k == 2) ? 3'd0 : (k == 9) ? 3'd1 : 3'd4)) begin
          miscompares++;
          $display("FAIL b2b_sel k=%0d got %0d required %0d", k, bus.mux_select, (k == 2) ? 0 : (k == 9) ? 1 : 4);
        end
      end
      if (k == 6) begin
        vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready k=6 got %0b required 1", bus.req_ready); end
        push_expected(3'd1);
      end
      if (k == 7) begin
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_second_accept got busy=%0b required 1", bus.busy); end
        bus.req_valid = 1'b0;
      end
    end
    vectors++; if (ndone !== 2 || d1 !== 6 || d2 !== 12) begin miscompares++; $display("FAIL b2b_done got n=%0d at %0d,%0d required 2 at 6,12", ndone, d1, d2); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_select = '0;
    bus.mux_pin_ena = 1'b1;
    bus.mux_func_receive = 3'b001;
    test_reset();
    test_switch();
    test_noop();
    test_error();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d outstanding required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
